// File: rtl/packed_field_update_scheduler_if.sv
// rtl/packed_field_update_scheduler_if.sv - request/commit bundle for the packed field update scheduler
interface packed_field_update_scheduler_if #(
    parameter int FIELD_W = 1,
    parameter int DELAY_W = 4
);
    logic [2:0]           req;
    logic [3*FIELD_W-1:0] req_data;
    logic [3*DELAY_W-1:0] req_delay;
    logic [2:0]           req_ack;
    logic [3*FIELD_W-1:0] signals_q;
    logic                 commit_valid;
    logic [1:0]           commit_idx;
    logic [2:0]           pending;

    modport master (
        output req, req_data, req_delay,
        input  req_ack, signals_q, commit_valid, commit_idx, pending
    );

    modport slave (
        input  req, req_data, req_delay,
        output req_ack, signals_q, commit_valid, commit_idx, pending
    );
endinterface

// File: rtl/packed_field_update_scheduler.sv
// rtl/packed_field_update_scheduler.sv - delayed per-field writes into packed {x,y,z}; optional INERTIAL_UPDATE_EN
module packed_field_update_scheduler #(
    parameter int                   FIELD_W   = 1,
    parameter int                   DELAY_W   = 4,
    parameter logic [3*FIELD_W-1:0] RESET_VAL = '0
) (
    input logic clk,
    input logic rst_n,
    packed_field_update_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, READY} slot_state_t;

    slot_state_t          state_q [3];
    slot_state_t          state_d [3];
    logic [DELAY_W-1:0]   cnt_q   [3];
    logic [DELAY_W-1:0]   cnt_d   [3];
    logic [FIELD_W-1:0]   data_q  [3];
    logic [FIELD_W-1:0]   data_d  [3];
    logic [1:0]           ptr_q, ptr_d;
    logic [2:0]           ready, grant, accept;
    logic                 found;
    logic [1:0]           gidx;
    logic [3*FIELD_W-1:0] sig_q, sig_d;
    logic                 cv_q;
    logic [1:0]           ci_q;

    always_comb begin
        ready  = '0;
        accept = '0;
        for (int i = 0; i < 3; i++) begin
            ready[i] = (state_q[i] == READY);
`ifdef INERTIAL_UPDATE_EN
            accept[i] = bus.req[i] && rst_n;
`else
            accept[i] = bus.req[i] && rst_n && (state_q[i] == IDLE);
`endif
        end
    end

    // Round-robin: first READY slot at or after the pointer wins.
    always_comb begin
        int s;
        grant = '0;
        found = 1'b0;
        gidx  = 2'd0;
        s     = 0;
        for (int k = 0; k < 3; k++) begin
            s = int'(ptr_q) + k;
            if (s >= 3) s = s - 3;
            if (!found && ready[s]) begin
                found    = 1'b1;
                grant[s] = 1'b1;
                gidx     = 2'(s);
            end
        end
        ptr_d = found ? ((gidx == 2'd2) ? 2'd0 : 2'(gidx + 2'd1)) : ptr_q;
    end

    // A new accept takes priority over grant: the old value still commits from data_q.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            data_d[i]  = data_q[i];
            if (accept[i]) begin
                data_d[i]  = bus.req_data[i*FIELD_W +: FIELD_W];
                cnt_d[i]   = bus.req_delay[i*DELAY_W +: DELAY_W];
                state_d[i] = (bus.req_delay[i*DELAY_W +: DELAY_W] == '0) ? READY : WAIT;
            end else begin
                case (state_q[i])
                    WAIT: begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                        if (cnt_q[i] == 1) state_d[i] = READY;
                    end
                    READY: if (grant[i]) state_d[i] = IDLE;
                    default: ;
                endcase
            end
        end
    end

    // Slot i lands in field (2-i) of the packed register: slot 0 is x at the MSB.
    always_comb begin
        sig_d = sig_q;
        for (int i = 0; i < 3; i++)
            if (grant[i]) sig_d[(2-i)*FIELD_W +: FIELD_W] = data_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                data_q[i]  <= '0;
            end
            ptr_q <= 2'd0;
            sig_q <= RESET_VAL;
            cv_q  <= 1'b0;
            ci_q  <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                data_q[i]  <= data_d[i];
            end
            ptr_q <= ptr_d;
            sig_q <= sig_d;
            cv_q  <= found;
            ci_q  <= found ? gidx : 2'd0;
        end
    end

    always_comb begin
        bus.pending = '0;
        for (int i = 0; i < 3; i++) bus.pending[i] = (state_q[i] != IDLE);
    end

    assign bus.req_ack      = accept;
    assign bus.signals_q    = sig_q;
    assign bus.commit_valid = cv_q;
    assign bus.commit_idx   = ci_q;
endmodule

// File: tb/tb_packed_field_update_scheduler.sv
// tb/tb_packed_field_update_scheduler.sv - scoreboard bench for packed_field_update_scheduler
module tb_packed_field_update_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        int         idx;
        logic [2:0] sig;
        int         at_edge;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] exp_sig;

    packed_field_update_scheduler_if #(.FIELD_W(1), .DELAY_W(4)) bus ();

    packed_field_update_scheduler #(.FIELD_W(1), .DELAY_W(4), .RESET_VAL(3'b000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic v, input int at);
        exp_sig[2-idx] = v;
        sb.push_back('{idx, exp_sig, at});
    endtask

    task automatic set_req(input int slot, input logic d, input int dly);
        bus.req[slot]              = 1'b1;
        bus.req_data[slot]         = d;
        bus.req_delay[slot*4 +: 4] = 4'(dly);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        exp_sig = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.commit_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 32'(cyc), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("commit_idx", 32'(bus.commit_idx), 32'(e.idx));
                check("commit_sig", 32'(bus.signals_q), 32'(e.sig));
                check("commit_edge", 32'(cyc), 32'(e.at_edge));
            end
        end
    end

    initial begin
        int a, b, e, refusals;
        rst_n         = 1'b0;
        exp_sig       = '0;
        bus.req       = 3'b111;
        bus.req_data  = '0;
        bus.req_delay = '0;
        #12;
        check("rst_sig", 32'(bus.signals_q), 0);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_cv", 32'(bus.commit_valid), 0);
        check("rst_ci", 32'(bus.commit_idx), 0);
        check("rst_ack", 32'(bus.req_ack), 0);
        bus.req = '0;
        tick();
        rst_n = 1'b1;

        // single delayed write, D=10
        set_req(0, 1'b1, 10);
        @(negedge clk);
        check("t1_ack", 32'(bus.req_ack), 32'b001);
        tick();
        a = cyc;
        bus.req = '0;
        push(0, 1'b1, a + 11);
        check("t1_pending", 32'(bus.pending), 32'b001);
        repeat (13) tick();
        check("t1_idle", 32'(bus.pending), 0);
        check("t1_sig", 32'(bus.signals_q), 32'b100);

        // zero delay on slot 2
        do_reset();
        set_req(2, 1'b1, 0);
        tick();
        a = cyc;
        bus.req = '0;
        push(2, 1'b1, a + 1);
        repeat (2) tick();
        check("t2_sig", 32'(bus.signals_q), 32'b001);

        // three-way contention
        do_reset();
        set_req(0, 1'b1, 2);
        set_req(1, 1'b1, 2);
        set_req(2, 1'b1, 2);
        @(negedge clk);
        check("t3_ack", 32'(bus.req_ack), 32'b111);
        tick();
        a = cyc;
        bus.req = '0;
        push(0, 1'b1, a + 3);
        push(1, 1'b1, a + 4);
        push(2, 1'b1, a + 5);
        repeat (6) tick();
        check("t3_sig", 32'(bus.signals_q), 32'b111);

        // fairness between slots 0 and 1
        do_reset();
        set_req(0, 1'b1, 0);
        set_req(1, 1'b1, 0);
        tick();
        e = cyc;
        push(0, 1'b1, e + 1);
        push(1, 1'b1, e + 2);
        push(0, 1'b1, e + 3);
        push(1, 1'b1, e + 4);
        push(0, 1'b1, e + 5);
        push(1, 1'b1, e + 6);
`ifdef INERTIAL_UPDATE_EN
        push(0, 1'b1, e + 7);
`endif
        repeat (5) tick();
        bus.req = '0;
        repeat (5) tick();
        check("t4_sig", 32'(bus.signals_q), 32'b110);

        // busy slot refusal
        do_reset();
        set_req(1, 1'b1, 8);
        tick();
        a = cyc;
        bus.req = '0;
`ifndef INERTIAL_UPDATE_EN
        push(1, 1'b1, a + 9);
`endif
        repeat (2) tick();
        set_req(1, 1'b0, 1);
        refusals = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_ack[1]) break;
            refusals++;
            tick();
        end
        tick();
        b = cyc;
        bus.req = '0;
`ifdef INERTIAL_UPDATE_EN
        check("t5_accept_edge", 32'(b), 32'(a + 3));
        check("t5_refusals", 32'(refusals), 0);
`else
        check("t5_accept_edge", 32'(b), 32'(a + 10));
        check("t5_refusals", 32'(refusals), 7);
`endif
        push(1, 1'b0, b + 2);
        repeat (4) tick();
        check("t5_sig", 32'(bus.signals_q), 0);

        // asynchronous reset while slot 0 waits with cnt=5
        do_reset();
        set_req(0, 1'b1, 9);
        set_req(2, 1'b1, 0);
        tick();
        a = cyc;
        bus.req = '0;
        push(2, 1'b1, a + 1);
        repeat (4) tick();
        check("t6_pending_pre", 32'(bus.pending), 32'b001);
        check("t6_sig_pre", 32'(bus.signals_q), 32'b001);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_pending_rst", 32'(bus.pending), 0);
        check("t6_sig_rst", 32'(bus.signals_q), 0);
        check("t6_cv_rst", 32'(bus.commit_valid), 0);
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        check("t6_sig_after", 32'(bus.signals_q), 0);

        check("sb_drain", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/packed_field_update_scheduler.md
Name: packed_field_update_scheduler

Overview:
- Schedules delayed writes into a packed three-field register `{x, y, z}` (x at MSB).
- Three requesters (slot 0 = x, slot 1 = y, slot 2 = z) each post a value plus a cycle delay.
- Each slot counts down its own delay; matured updates share the single register write port through a round-robin arbiter.
- Gives synthesizable, cycle-accurate replacement for intra-assignment delayed updates of struct fields in testbench and datapath code.

Parameters:
- FIELD_W, 1, width of each of x, y, z
- DELAY_W, 4, width of each per-slot delay value (max delay 2^DELAY_W-1)
- RESET_VAL, 0, reset value of the packed register (3*FIELD_W bits)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  3  per-slot write request, held until acked
- req_data  in  3*FIELD_W  slot i value at bits [i*FIELD_W +: FIELD_W]
- req_delay  in  3*DELAY_W  slot i delay at bits [i*DELAY_W +: DELAY_W]
- req_ack  out  3  combinational: request accepted at this edge
- signals_q  out  3*FIELD_W  packed register: x=[3F-1:2F], y=[2F-1:F], z=[F-1:0]
- commit_valid  out  1  registered: a field was written at the last edge
- commit_idx  out  2  registered: slot committed (0..2); 0 when commit_valid=0
- pending  out  3  per-slot: slot not IDLE

Behaviour:
- Reset (async assert, sync release):
  - signals_q=RESET_VAL, commit_valid=0, commit_idx=0, pending=0, req_ack=0.
  - All slots go to IDLE, RR pointer=0, any in-flight update discarded.
- Per-slot FSM (IDLE, WAIT, READY):
  - IDLE: req_ack[i]=req[i]. On accept, latch data and cnt=delay. Go to READY if delay==0, else WAIT.
  - WAIT: cnt decrements each cycle. When cnt==1, go to READY.
  - READY: hold until granted, then go to IDLE.
  - pending[i] = state!=IDLE, registered.
- Latency: with no contention, the field is visible in signals_q exactly D+1 edges after the accept edge.
  - D=0 → 1 edge; D=15 → 16 edges.
- Arbitration:
  - At most one commit per cycle.
  - Round-robin over READY slots, starting at the pointer.
  - After a grant, pointer = granted+1 mod 3.
  - Losing slots stay READY; their latched data is unchanged.
- Commit: only the granted field's bits of signals_q change; other fields hold. commit_valid=1 and commit_idx=slot in the same edge.
- Busy slot: req[i] while slot not IDLE gives req_ack[i]=0; the requester must hold.
  - A slot granted at edge k can accept a new request at edge k+1 at the earliest, never the same edge.
- Requests on different slots are independent and may be accepted in the same cycle.
- Reset mid-WAIT or mid-READY: update dropped, signals_q returns to RESET_VAL.

Optional Feature:
- Macro: INERTIAL_UPDATE_EN
- Defined (inertial semantics):
  - req[i] on a WAIT or READY slot is acked immediately.
  - It replaces latched data and cnt, and restarts the timer (READY if delay 0).
  - If the slot is granted in the same cycle, the old value commits and the new request is loaded as a fresh WAIT/READY entry.
- Undefined: busy slots refuse requests as described under Behaviour (transport semantics, no cancellation).

Test Plan:
- Single delayed write:
  - Stimulus: reset, then slot0 req with data=1, delay=10, accepted at edge 0.
  - Required: x=1 at edge 11; commit_valid=1 and commit_idx=0 for exactly one cycle; y and z stay 0.
- Zero delay:
  - Stimulus: slot2 data=1, delay=0.
  - Required: signals_q=3'b001 one edge after accept.
- Three-way contention:
  - Stimulus: all slots delay=2, accepted on the same edge.
  - Required: commits on consecutive edges in order x, y, z (pointer starts at 0); signals_q=3'b111 after 5 edges.
- Fairness:
  - Stimulus: slots 0 and 1 re-request continuously with delay 0.
  - Required: commit_idx alternates 0,1,0,1; no slot starved.
- Busy refusal (macro undefined):
  - Stimulus: slot1 delay=8, then a second req at cycle 3.
  - Required: second req has req_ack=0 until the cycle after the first commit; then accepted.
  - With INERTIAL_UPDATE_EN: acked at cycle 3; the first value never appears.
- Reset mid-operation:
  - Stimulus: slot0 in WAIT with cnt=5; assert rst_n=0 asynchronously.
  - Required: pending=0 and signals_q=RESET_VAL immediately, with no later commit.
